bcd_bin_seq: RTL and testbench

- Sequential BCD-to-binary converter. It is the reverse direction of the team's combinational binary-to-BCD block.
- Takes a packed multi-digit BCD word and produces the equivalent unsigned binary value.
- Uses reverse double-dabble: shift right, then subtract 3 from any digit that is 8 or more.
- Runs under a start/busy/done handshake. Sits between the BCD keypad/display datapath and binary arithmetic logic.

---
 rtl/bcd_bin_seq_if.sv | 43 ++++
 rtl/bcd_bin_seq.sv | 137 +++++++++++++
 tb/tb_bcd_bin_seq.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_bin_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_bin_seq_if
//  Purpose  : Handshake and data bundle for the sequential BCD-to-binary
//             converter.
//  Signals  : start   - request a conversion of bcd_in (master -> slave)
//             bcd_in  - packed BCD word, digit 0 in bits [3:0]
//             busy    - conversion in progress (slave -> master)
//             done    - one-cycle pulse when bin_out/err are updated
//             bin_out - converted unsigned binary value
//             err     - input held a digit greater than 9
//  Revision : 1.0 - initial release
// ============================================================================
interface bcd_bin_seq_if #(
    parameter int DIGITS = 2,
    parameter int BIN_W  = 7
);
    logic                  start;
    logic [4*DIGITS-1:0]   bcd_in;
    logic                  busy;
    logic                  done;
    logic [BIN_W-1:0]      bin_out;
    logic                  err;

    modport master (
        output start,
        output bcd_in,
        input  busy,
        input  done,
        input  bin_out,
        input  err
    );

    modport slave (
        input  start,
        input  bcd_in,
        output busy,
        output done,
        output bin_out,
        output err
    );
endinterface
`default_nettype wire

// File: rtl/bcd_bin_seq.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_bin_seq
//  Purpose  : Sequential BCD-to-binary converter using reverse double-dabble.
//             Each SHIFT cycle shifts {R,Q} right by one bit and then takes 3
//             off every BCD nibble of R that reads 8 or more. After BIN_W
//             shifts Q holds the binary value and R is empty.
//  Ports    : clk   - system clock, rising edge
//             rst_n - asynchronous active-low reset
//             bus   - bcd_bin_seq_if slave modport (start/bcd_in in,
//                     busy/done/bin_out/err out)
//  Revision : 1.0 - initial release
// ============================================================================
module bcd_bin_seq #(
    parameter int DIGITS = 2,
    parameter int BIN_W  = 7
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    bcd_bin_seq_if.slave    bus
);

    localparam int c_BCD_W = 4 * DIGITS;
    localparam int c_CAT_W = c_BCD_W + BIN_W;
    localparam int c_CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(BIN_W - 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SHIFT = 2'd1;
    localparam logic [1:0] c_FIN   = 2'd2;

    logic [1:0]          r_state;
    logic [c_BCD_W-1:0]  r_bcd;
    logic [BIN_W-1:0]    r_bin;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_err_pend;
    logic                r_busy;
    logic                r_done;
    logic [BIN_W-1:0]    r_bin_out;
    logic                r_err;

    logic [DIGITS-1:0]   w_bad;
    logic                w_invalid;
    logic [c_CAT_W-1:0]  w_cat;
    logic [c_BCD_W-1:0]  w_bcd_sh;
    logic [c_BCD_W-1:0]  w_bcd_fix;
    logic [BIN_W-1:0]    w_bin_sh;

    // The LSB of R falls into the MSB of Q on every shift.
    assign w_cat    = {r_bcd, r_bin} >> 1;
    assign w_bcd_sh = w_cat[c_CAT_W-1:BIN_W];
    assign w_bin_sh = w_cat[BIN_W-1:0];

    for (genvar i = 0; i < DIGITS; i++) begin : g_nib
        assign w_bad[i] = (bus.bcd_in[4*i +: 4] > 4'd9);
        // A nibble that reads 8+ after the shift received a '10' from the
        // digit above; weight 10 halved is 5, but it landed as 8, so take 3.
        assign w_bcd_fix[4*i +: 4] = (w_bcd_sh[4*i +: 4] >= 4'd8)
                                   ? (w_bcd_sh[4*i +: 4] - 4'd3)
                                   : w_bcd_sh[4*i +: 4];
    end

    assign w_invalid = |w_bad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_IDLE;
            r_bcd      <= '0;
            r_bin      <= '0;
            r_cnt      <= '0;
            r_err_pend <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_bin_out  <= '0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_bcd <= bus.bcd_in;
                        r_bin <= '0;
                        r_cnt <= '0;
                        if (w_invalid) begin
                            // Skip the shift phase; FIN raises done next edge.
                            r_err_pend <= 1'b1;
                            r_state    <= c_FIN;
                        end else begin
                            r_err_pend <= 1'b0;
                            r_busy     <= 1'b1;
                            r_state    <= c_SHIFT;
                        end
                    end
                end
                c_SHIFT: begin
                    r_bcd <= w_bcd_fix;
                    r_bin <= w_bin_sh;
                    r_cnt <= r_cnt + c_CNT_W'(1);
                    if (r_cnt == c_LAST) begin
                        // Last shift: publish the result on this same edge so
                        // the FIN cycle is the done cycle.
                        r_state   <= c_FIN;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_bin_out <= w_bin_sh;
                        r_err     <= 1'b0;
                    end
                end
                c_FIN: begin
                    if (r_err_pend) begin
                        // Invalid input spends one extra cycle here so done
                        // is still a registered, single-cycle pulse.
                        r_err_pend <= 1'b0;
                        r_done     <= 1'b1;
                        r_bin_out  <= '0;
                        r_err      <= 1'b1;
                    end else begin
                        r_done  <= 1'b0;
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.bin_out = r_bin_out;
    assign bus.err     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_bcd_bin_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bcd_bin_seq
//  Purpose  : Self-checking bench for bcd_bin_seq. A 2-digit instance covers
//             reset, latency, boundaries, invalid digits, busy protection and
//             mid-conversion reset; a 3-digit instance covers the full sweep
//             of valid codes with start held high.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_bin_seq;

    logic clk;
    logic rst_n;

    int n_tests;
    int n_fail;

    bcd_bin_seq_if #(.DIGITS(2), .BIN_W(7))  if2 ();
    bcd_bin_seq_if #(.DIGITS(3), .BIN_W(10)) if3 ();

    bcd_bin_seq #(.DIGITS(2), .BIN_W(7)) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if2.slave)
    );

    bcd_bin_seq #(.DIGITS(3), .BIN_W(10)) u_dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if3.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: decimal value of a packed BCD word, plus validity.
    function automatic int ref_val(input logic [11:0] code, input int nd, output bit ok);
        int v;
        int w;
        v  = 0;
        w  = 1;
        ok = 1'b1;
        for (int i = 0; i < nd; i++) begin
            int d;
            d = int'(code[4*i +: 4]);
            if (d > 9) ok = 1'b0;
            v += d * w;
            w *= 10;
        end
        return ok ? v : 0;
    endfunction

    function automatic logic [11:0] to_bcd(input int v);
        logic [11:0] r;
        r = '0;
        for (int i = 0; i < 3; i++) begin
            r[4*i +: 4] = 4'((v / (10 ** i)) % 10);
        end
        return r;
    endfunction

    // Drives one conversion on the 2-digit instance (caller sits just after
    // a rising edge, DUT idle). lat counts edges after the start edge until
    // done is observed, -1 if it never shows.
    task automatic run2(input logic [7:0] code, output int lat, output logic busy_e,
                        output logic [6:0] bin, output logic e);
        if2.bcd_in = code;
        if2.start  = 1'b1;
        @(posedge clk); #1;
        if2.start = 1'b0;
        busy_e    = if2.busy;
        lat       = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (if2.done) begin
                lat = k;
                break;
            end
        end
        bin = if2.bin_out;
        e   = if2.err;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst_n      = 1'b0;
        if2.start  = 1'b0;
        if2.bcd_in = '0;
        if3.start  = 1'b0;
        if3.bcd_in = '0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (if2.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", if2.busy); end
        n_tests++;
        if (if2.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", if2.done); end
        n_tests++;
        if (if2.bin_out !== 7'd0) begin n_fail++; $display("FAIL reset_bin got %0d want 0", if2.bin_out); end
        n_tests++;
        if (if2.err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", if2.err); end
        n_tests++;
        if ({if3.busy, if3.done, if3.err, if3.bin_out} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_dut3 got %h want 0", {if3.busy, if3.done, if3.err, if3.bin_out});
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        int lat; logic b; logic [6:0] v; logic e;
        run2(8'h42, lat, b, v, e);
        n_tests++;
        if (b !== 1'b1) begin n_fail++; $display("FAIL basic_busy got %b want 1", b); end
        n_tests++;
        if (lat != 7) begin n_fail++; $display("FAIL basic_latency got %0d want 7", lat); end
        n_tests++;
        if (v !== 7'd42) begin n_fail++; $display("FAIL basic_value got %0d want 42", v); end
        n_tests++;
        if (e !== 1'b0) begin n_fail++; $display("FAIL basic_err got %b want 0", e); end
        n_tests++;
        if (if2.done !== 1'b0) begin n_fail++; $display("FAIL basic_done_width got %b want 0", if2.done); end
    endtask

    task automatic test_values;
        logic [7:0] codes [$];
        codes = '{8'h00, 8'h99, 8'h09, 8'h10};
        for (int i = 0; i < 24; i++) codes.push_back(8'($urandom));
        foreach (codes[i]) begin
            int lat; logic b; logic [6:0] v; logic e; bit ok; int exp;
            exp = ref_val({4'h0, codes[i]}, 2, ok);
            run2(codes[i], lat, b, v, e);
            n_tests++;
            if (lat != (ok ? 7 : 1)) begin
                n_fail++; $display("FAIL value_latency code %h got %0d want %0d", codes[i], lat, ok ? 7 : 1);
            end
            n_tests++;
            if (b !== ok) begin n_fail++; $display("FAIL value_busy code %h got %b want %b", codes[i], b, ok); end
            n_tests++;
            if (v !== 7'(exp) || e !== !ok) begin
                n_fail++;
                $display("FAIL value code %h got %0d err %b want %0d err %b", codes[i], v, e, exp, !ok);
            end
        end
    endtask

    task automatic test_invalid;
        int lat; logic b; logic [6:0] v; logic e;
        run2(8'hA5, lat, b, v, e);
        n_tests++;
        if (lat != 1) begin n_fail++; $display("FAIL invalid_latency got %0d want 1", lat); end
        n_tests++;
        if (e !== 1'b1 || v !== 7'd0) begin n_fail++; $display("FAIL invalid_out got %0d err %b want 0 err 1", v, e); end
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (if2.err !== 1'b1 || if2.bin_out !== 7'd0) begin
            n_fail++; $display("FAIL invalid_hold got %0d err %b want 0 err 1", if2.bin_out, if2.err);
        end
        run2(8'h37, lat, b, v, e);
        n_tests++;
        if (e !== 1'b0 || v !== 7'd37 || lat != 7) begin
            n_fail++; $display("FAIL after_invalid got %0d err %b lat %0d want 37 err 0 lat 7", v, e, lat);
        end
    endtask

    task automatic test_busy_protect;
        int dones; logic [6:0] v;
        dones = 0;
        v     = '0;
        if2.bcd_in = 8'h25;
        if2.start  = 1'b1;
        @(posedge clk); #1;
        if2.start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        if2.bcd_in = 8'h99;
        if2.start  = 1'b1;
        @(posedge clk); #1;
        if2.start  = 1'b0;
        if2.bcd_in = 8'h00;
        for (int k = 0; k < 30; k++) begin
            if (if2.done) begin dones++; v = if2.bin_out; end
            @(posedge clk); #1;
        end
        n_tests++;
        if (dones != 1) begin n_fail++; $display("FAIL busy_protect_dones got %0d want 1", dones); end
        n_tests++;
        if (v !== 7'd25) begin n_fail++; $display("FAIL busy_protect_value got %0d want 25", v); end
    endtask

    task automatic test_reset_mid;
        int dones; int lat; logic b; logic [6:0] v; logic e;
        dones = 0;
        if2.bcd_in = 8'h64;
        if2.start  = 1'b1;
        @(posedge clk); #1;
        if2.start = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        n_tests++;
        if (if2.busy !== 1'b1) begin n_fail++; $display("FAIL reset_mid_busy_before got %b want 1", if2.busy); end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({if2.busy, if2.done, if2.err, if2.bin_out} !== 10'd0) begin
            n_fail++; $display("FAIL reset_mid_outputs got %h want 0", {if2.busy, if2.done, if2.err, if2.bin_out});
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (if2.done || if2.busy) dones++;
        end
        n_tests++;
        if (dones != 0) begin n_fail++; $display("FAIL reset_mid_no_done got %0d active cycles want 0", dones); end
        run2(8'h64, lat, b, v, e);
        n_tests++;
        if (v !== 7'd64 || e !== 1'b0 || lat != 7) begin
            n_fail++; $display("FAIL reset_mid_rerun got %0d err %b lat %0d want 64 err 0 lat 7", v, e, lat);
        end
    endtask

    task automatic test_back_to_back;
        int last_t; int t; int lat;
        last_t = -1;
        t      = 0;
        if3.start = 1'b1;
        for (int code = 0; code < 1000; code++) begin
            bit ok; int exp;
            if3.bcd_in = to_bcd(code);
            exp = ref_val(to_bcd(code), 3, ok);
            lat = -1;
            for (int k = 0; k < 40; k++) begin
                @(posedge clk); #1;
                t++;
                if (if3.done) begin lat = k; break; end
            end
            n_tests++;
            if (lat < 0 || if3.bin_out !== 10'(exp) || if3.err !== 1'b0) begin
                n_fail++;
                $display("FAIL sweep code %0d got %0d err %b want %0d err 0", code, if3.bin_out, if3.err, exp);
            end
            if (last_t >= 0) begin
                n_tests++;
                if (t - last_t != 12) begin
                    n_fail++; $display("FAIL sweep_spacing code %0d got %0d want 12", code, t - last_t);
                end
            end
            last_t = t;
        end
        if3.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_basic();
        test_values();
        test_invalid();
        test_busy_protect();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
